// File: rtl/mainfsm.sv
// Multicycle controller FSM for the ARM-subset processor.
// Moore machine sequencing fetch/decode/execute/memory/writeback steps.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t state;
    state_t state_next;

    // State register; reset aborts any instruction back to FETCH at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Op/Funct only matter when leaving DECODE or MEMADR.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH: state_next = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    // Output decode; every control signal is a function of state alone.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                ALUOp = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed instructions, random mixes,
// random don't-care inputs and reset scenarios against a behavioural model.
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [3:0] State;

    int passed;
    int total;

    typedef int seq_t[$];

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected step sequence of one instruction, from its Op/Funct.
    function automatic seq_t expect_seq(input logic [1:0] op,
                                        input logic [5:0] fn);
        seq_t q;
        q = {0, 1};
        if (op == 2'b00) begin
            q.push_back(fn[5] ? 7 : 6);
            q.push_back(8);
        end else if (op == 2'b01) begin
            q.push_back(2);
            if (fn[0]) begin
                q.push_back(3);
                q.push_back(4);
            end else begin
                q.push_back(5);
            end
        end else if (op == 2'b10) begin
            q.push_back(9);
        end else begin
            q.push_back(10);
        end
        return q;
    endfunction

    // Control word {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,
    // NextPC,RegW,MemW,Branch,ALUOp} expected in each step.
    function automatic logic [12:0] expect_ctrl(input int s);
        logic [12:0] w;
        case (s)
            0:  w = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 5'b10000};
            1:  w = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 5'b00000};
            2:  w = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 5'b00000};
            3:  w = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 5'b00000};
            4:  w = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 5'b01000};
            5:  w = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 5'b00100};
            6:  w = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 5'b00001};
            7:  w = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 5'b00001};
            8:  w = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 5'b01000};
            9:  w = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 5'b00010};
            default: w = 13'd0;
        endcase
        return w;
    endfunction

    function automatic logic [12:0] ctrl_now();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                NextPC, RegW, MemW, Branch, ALUOp};
    endfunction

    // Runs one instruction from FETCH and checks every step.
    // With junk set, Op/Funct are randomized wherever they are don't-care.
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] fn, input bit junk);
        seq_t q;
        int   pulses;
        q = expect_seq(op, fn);
        pulses = 0;
        foreach (q[i]) begin
            total++;
            if (State !== 4'(q[i]) || ctrl_now() !== expect_ctrl(q[i])) begin
                $display("FAIL %s step %0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                         name, i, State, ctrl_now(), q[i], expect_ctrl(q[i]));
            end else begin
                passed++;
            end
            if (NextPC === 1'b1) pulses++;
            if (q[i] == 1 || q[i] == 2 || !junk) begin
                Op    = op;
                Funct = fn;
            end else begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (State !== 4'd0 || pulses != 1) begin
            $display("FAIL %s end: state=%0d nextpc_pulses=%0d required state=0 pulses=1",
                     name, State, pulses);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1) begin
            $display("FAIL reset_hold: state=%0d irw=%b npc=%b required 0/1/1",
                     State, IRWrite, NextPC);
        end else begin
            passed++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (State !== 4'd1) begin
            $display("FAIL reset_release: state=%0d required 1", State);
        end else begin
            passed++;
        end
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0) begin
            $display("FAIL reset_async: state=%0d required 0", State);
        end else begin
            passed++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        run_instr("add_reg", 2'b00, 6'b001000, 1'b0);
        run_instr("add_imm", 2'b00, 6'b101001, 1'b0);
        run_instr("ldr", 2'b01, 6'b011001, 1'b0);
        run_instr("str", 2'b01, 6'b011000, 1'b0);
        run_instr("branch", 2'b10, 6'b000000, 1'b0);
        run_instr("undef", 2'b11, 6'b000000, 1'b0);
    endtask

    task automatic test_reset_mid();
        Op    = 2'b00;
        Funct = 6'b001000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (State !== 4'd8 || RegW !== 1'b1) begin
            $display("FAIL mid_alwb: state=%0d regw=%b required 8/1", State, RegW);
        end else begin
            passed++;
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || RegW !== 1'b0 || MemW !== 1'b0 ||
            Branch !== 1'b0) begin
            $display("FAIL mid_reset: state=%0d regw=%b memw=%b br=%b required 0/0/0/0",
                     State, RegW, MemW, Branch);
        end else begin
            passed++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [5:0] fn;
        run_instr("b2b_ldr", 2'b01, 6'b011001, 1'b1);
        run_instr("b2b_str", 2'b01, 6'b011000, 1'b1);
        run_instr("b2b_b", 2'b10, 6'b101010, 1'b1);
        run_instr("b2b_add", 2'b00, 6'b001000, 1'b1);
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom);
            fn = 6'($urandom);
            run_instr($sformatf("rand%0d", k), op, fn, 1'b1);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
